instr_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register/next-PC logic.
- Takes the current PC, runs one read on the instruction-memory request/response channel, and presents the instruction with a valid/ready handshake to decode/execute.
- Emits pc_step, the enable that advances the PC register when an instruction retires.
- Detects misaligned PCs, bus errors and response timeouts, and reports them as fetch faults instead of instructions.

---
 rtl/instr_fetch_pkg.sv | 32 +++
 rtl/fetch_timeout_ctr.sv | 34 +++
 rtl/instr_fetch.sv | 159 +++++++++++++++
 tb/tb_instr_fetch.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// fetch fault cause codes, the canonical NOP and the timeout counter width.
package instr_fetch_pkg;

    // Fetch FSM states
    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_REQ   = 3'd1,
        FETCH_WAIT  = 3'd2,
        FETCH_HOLD  = 3'd3,
        FETCH_DRAIN = 3'd4
    } fetch_state_e;

    // Fault cause codes reported on fault_cause
    typedef enum logic [1:0] {
        FETCH_MISALIGN = 2'd0,
        FETCH_BUSERR   = 2'd1,
        FETCH_TIMEOUT  = 2'd2
    } fetch_cause_e;

    // addi x0, x0, 0 -- presented in place of an instruction on faults
    localparam logic [31:0] NOP_ENCODING = 32'h00000013;

    // Width of the response timeout counter; it saturates rather than wraps
    localparam int TIMEOUT_CTR_W = 16;

    // A fetch PC must be word aligned; only the two low bits matter
    function automatic logic pc_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Response timeout counter for the fetch stage. Cleared when a request is
// granted, counts every enabled cycle and saturates at all-ones. 'expired'
// goes high during the TIMEOUT-th enabled cycle since the clear, so the
// FSM can leave WAIT after exactly TIMEOUT cycles without a response.
module fetch_timeout_ctr
    import instr_fetch_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_CTR_W-1:0] LIMIT = TIMEOUT_CTR_W'(TIMEOUT - 1);

    logic [TIMEOUT_CTR_W-1:0] count;

    // Count enabled cycles since the last clear, holding at the top value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage. Latches the PC, performs a single read on the
// instruction-memory request/response channel and presents the result to
// decode with a valid/ready handshake. Misaligned PCs, bus errors and
// response timeouts become fault records carrying a NOP instead of data.
// pc_step tells the PC register to advance when an instruction retires.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] fetch_pc,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        pc_step
);

    fetch_state_e state;
    fetch_state_e state_next;

    logic drain_pending;
    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;
    logic launch;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush is checked first in every state it affects
    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE: begin
                state_next = pc_misaligned(pc[1:0]) ? FETCH_HOLD : FETCH_REQ;
            end
            FETCH_REQ: begin
                if (flush) begin
                    // A granted request still owes us a response, so drain it
                    state_next = imem_gnt ? FETCH_DRAIN : FETCH_IDLE;
                end else if (imem_gnt) begin
                    state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (flush) begin
                    // If the response lands with the flush it is already consumed
                    state_next = imem_rvalid ? FETCH_IDLE : FETCH_DRAIN;
                end else if (imem_rvalid || tmo_expired) begin
                    state_next = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                // A timed-out request may still answer late; keep draining it
                // even on flush so it is never mistaken for the next response
                if (flush || instr_ready) begin
                    state_next = drain_pending ? FETCH_DRAIN : FETCH_IDLE;
                end
            end
            FETCH_DRAIN: begin
                if (imem_rvalid) begin
                    state_next = pc_misaligned(pc[1:0]) ? FETCH_HOLD : FETCH_REQ;
                end
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    // Outputs and control strobes decoded from the current state
    always_comb begin
        imem_req    = (state == FETCH_REQ);
        instr_valid = (state == FETCH_HOLD);
        pc_step     = (state == FETCH_HOLD) && instr_ready && !flush;
        tmo_clear   = (state == FETCH_REQ) && imem_gnt;
        tmo_enable  = (state == FETCH_WAIT);
        launch      = (state == FETCH_IDLE) || ((state == FETCH_DRAIN) && imem_rvalid);
    end

    assign imem_addr = fetch_pc;

    // Fetch record: PC sampled on launch, instruction and fault on completion
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc    <= '0;
            instr       <= NOP_INSTR;
            fault       <= 1'b0;
            fault_cause <= 2'd0;
        end else if (launch) begin
            fetch_pc <= pc;
            if (pc_misaligned(pc[1:0])) begin
                instr       <= NOP_INSTR;
                fault       <= 1'b1;
                fault_cause <= FETCH_MISALIGN;
            end else begin
                fault       <= 1'b0;
                fault_cause <= 2'd0;
            end
        end else if ((state == FETCH_WAIT) && !flush) begin
            if (imem_rvalid) begin
                if (imem_err) begin
                    instr       <= NOP_INSTR;
                    fault       <= 1'b1;
                    fault_cause <= FETCH_BUSERR;
                end else begin
                    instr       <= imem_rdata;
                    fault       <= 1'b0;
                    fault_cause <= 2'd0;
                end
            end else if (tmo_expired) begin
                instr       <= NOP_INSTR;
                fault       <= 1'b1;
                fault_cause <= FETCH_TIMEOUT;
            end
        end
    end

    // Remember that a timed-out request still has a response in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drain_pending <= 1'b0;
        end else if ((state == FETCH_WAIT) && !flush && !imem_rvalid && tmo_expired) begin
            drain_pending <= 1'b1;
        end else if ((state == FETCH_DRAIN) && imem_rvalid) begin
            drain_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch. Inputs are driven 1ns after each
// rising edge and outputs are sampled at that point (comb outputs 1ns later).
// The DUT is built with TIMEOUT=4 so the timeout path is short.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rstn;
    logic [31:0] pc;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] fetch_pc;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        pc_step;

    int   n_checks     = 0;
    int   n_fail       = 0;
    int   pc_step_seen = 0;
    logic saw_deadbeef = 1'b0;

    instr_fetch #(
        .TIMEOUT   (4),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pc          (pc),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .fetch_pc    (fetch_pc),
        .fault       (fault),
        .fault_cause (fault_cause),
        .pc_step     (pc_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watch retirements and any leak of the discarded late response
    always @(negedge clk) begin
        if (pc_step === 1'b1) pc_step_seen++;
        if (instr === 32'hDEADBEEF) saw_deadbeef = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with quiet inputs, then release
    task automatic do_reset(input logic [31:0] start_pc);
        rstn        = 1'b0;
        pc          = start_pc;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        imem_err    = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn        = 1'b0;
        pc          = 32'h0;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        imem_err    = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({imem_req, instr_valid, fault, pc_step} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got req/valid/fault/step=%b expected 0000", {imem_req, instr_valid, fault, pc_step});
        end
        n_checks++;
        if (imem_addr !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_addr: got %h expected %h", imem_addr, 32'h0);
        end
        n_checks++;
        if (instr !== NOP) begin
            n_fail++;
            $display("[TB] FAIL reset_instr: got %h expected %h", instr, NOP);
        end
        n_checks++;
        if (fetch_pc !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_fetch_pc: got %h expected %h", fetch_pc, 32'h0);
        end
        n_checks++;
        if (fault_cause !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_cause: got %0d expected 0", fault_cause);
        end
    endtask

    task automatic test_first_fetch();
        do_reset(32'h0);
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t1_idle_req: got %b expected 0", imem_req);
        end
        tick();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL t1_cycle1_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        n_checks++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL t1_wait_flags: got req/valid=%b expected 00", {imem_req, instr_valid});
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00500093;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        n_checks++;
        if ({instr_valid, instr, fetch_pc, fault} !== {1'b1, 32'h00500093, 32'h0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL t1_cycle3_instr: got valid=%b instr=%h pc=%h fault=%b expected 1 00500093 00000000 0", instr_valid, instr, fetch_pc, fault);
        end
        instr_ready = 1'b1;
        #1;
        n_checks++;
        if (pc_step !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL t1_pc_step: got %b expected 1", pc_step);
        end
        tick();
        instr_ready = 1'b0;
        pc          = 32'h4;
        #1;
        n_checks++;
        if ({instr_valid, pc_step} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL t1_retired: got valid/step=%b expected 00", {instr_valid, pc_step});
        end
        tick();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin
            n_fail++;
            $display("[TB] FAIL t1_next_addr: got req=%b addr=%h expected req=1 addr=00000004", imem_req, imem_addr);
        end
    endtask

    task automatic test_misaligned();
        do_reset(32'h00000102);
        tick();
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t2_no_req: got %b expected 0", imem_req);
        end
        n_checks++;
        if ({instr_valid, fault, fault_cause} !== {1'b1, 1'b1, 2'd0}) begin
            n_fail++;
            $display("[TB] FAIL t2_fault: got valid=%b fault=%b cause=%0d expected 1 1 0", instr_valid, fault, fault_cause);
        end
        n_checks++;
        if (instr !== NOP) begin
            n_fail++;
            $display("[TB] FAIL t2_instr: got %h expected %h", instr, NOP);
        end
        n_checks++;
        if (fetch_pc !== 32'h00000102) begin
            n_fail++;
            $display("[TB] FAIL t2_fetch_pc: got %h expected 00000102", fetch_pc);
        end
        tick();
        n_checks++;
        if ({imem_req, instr_valid} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL t2_held: got req/valid=%b expected 01", {imem_req, instr_valid});
        end
    endtask

    task automatic test_bus_error();
        do_reset(32'h00000040);
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_err    = 1'b1;
        imem_rdata  = 32'h12345678;
        tick();
        imem_err    = 1'b0;
        // Stray responses while holding must be ignored
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAADF00D;
        n_checks++;
        if ({instr_valid, fault, fault_cause, instr} !== {1'b1, 1'b1, 2'd1, NOP}) begin
            n_fail++;
            $display("[TB] FAIL t3_buserr: got valid=%b fault=%b cause=%0d instr=%h expected 1 1 1 %h", instr_valid, fault, fault_cause, instr, NOP);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({instr_valid, instr, fetch_pc, fault, fault_cause, pc_step, imem_req} !== {1'b1, NOP, 32'h40, 1'b1, 2'd1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL t3_stable_%0d: got valid=%b instr=%h pc=%h fault=%b cause=%0d step=%b req=%b", i, instr_valid, instr, fetch_pc, fault, fault_cause, pc_step, imem_req);
            end
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b1;
        #1;
        n_checks++;
        if (pc_step !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL t3_retire: got pc_step=%b expected 1", pc_step);
        end
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_timeout_drain();
        do_reset(32'h00000080);
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        // Four WAIT cycles with no response before the fault appears
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (instr_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL t4_early_valid_%0d: got %b expected 0", i, instr_valid);
            end
            tick();
        end
        n_checks++;
        if ({instr_valid, fault, fault_cause, instr, fetch_pc} !== {1'b1, 1'b1, 2'd2, NOP, 32'h80}) begin
            n_fail++;
            $display("[TB] FAIL t4_timeout: got valid=%b fault=%b cause=%0d instr=%h pc=%h expected 1 1 2 %h 00000080", instr_valid, fault, fault_cause, instr, fetch_pc, NOP);
        end
        instr_ready = 1'b1;
        #1;
        n_checks++;
        if (pc_step !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL t4_retire: got pc_step=%b expected 1", pc_step);
        end
        tick();
        instr_ready = 1'b0;
        pc          = 32'h00000084;
        n_checks++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL t4_drain_enter: got req/valid=%b expected 00", {imem_req, instr_valid});
        end
        tick();
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t4_drain_wait: got req=%b expected 0", imem_req);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h84}) begin
            n_fail++;
            $display("[TB] FAIL t4_new_req: got req=%b addr=%h expected req=1 addr=00000084", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A00113;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        n_checks++;
        if ({instr_valid, instr, fault, fetch_pc} !== {1'b1, 32'h00A00113, 1'b0, 32'h84}) begin
            n_fail++;
            $display("[TB] FAIL t4_after_drain: got valid=%b instr=%h fault=%b pc=%h expected 1 00a00113 0 00000084", instr_valid, instr, fault, fetch_pc);
        end
        n_checks++;
        if (saw_deadbeef !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t4_deadbeef_leak: got seen=%b expected 0", saw_deadbeef);
        end
    endtask

    task automatic test_flush();
        int steps_before;
        do_reset(32'h00000100);
        steps_before = pc_step_seen;
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        pc    = 32'h00000200;
        n_checks++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL t5_flushed_wait: got req/valid=%b expected 00", {imem_req, instr_valid});
        end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBADBAD00;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        n_checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h200, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL t5_refetch: got req=%b addr=%h valid=%b expected 1 00000200 0", imem_req, imem_addr, instr_valid);
        end
        n_checks++;
        if (pc_step_seen !== steps_before) begin
            n_fail++;
            $display("[TB] FAIL t5_no_step: got %0d retirements expected %0d", pc_step_seen, steps_before);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00000093;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        n_checks++;
        if ({instr_valid, instr} !== {1'b1, 32'h00000093}) begin
            n_fail++;
            $display("[TB] FAIL t5_hold: got valid=%b instr=%h expected 1 00000093", instr_valid, instr);
        end
        flush       = 1'b1;
        instr_ready = 1'b1;
        #1;
        n_checks++;
        if (pc_step !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t5_flush_step: got pc_step=%b expected 0", pc_step);
        end
        tick();
        flush       = 1'b0;
        instr_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t5_hold_drop: got valid=%b expected 0", instr_valid);
        end
        tick();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("[TB] FAIL t5_hold_refetch: got req=%b addr=%h expected 1 00000200", imem_req, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        do_reset(32'h00000300);
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        // Mid-cycle reset while waiting for the response, no clock edge involved
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, instr_valid, fault, pc_step} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL t6_async_flags: got req/valid/fault/step=%b expected 0000", {imem_req, instr_valid, fault, pc_step});
        end
        n_checks++;
        if ({imem_addr, fetch_pc, instr, fault_cause} !== {32'h0, 32'h0, NOP, 2'd0}) begin
            n_fail++;
            $display("[TB] FAIL t6_async_regs: got addr=%h pc=%h instr=%h cause=%0d expected 0 0 %h 0", imem_addr, fetch_pc, instr, fault_cause, NOP);
        end
        pc = 32'h00000400;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFEF00D;
        @(posedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        @(posedge clk);
        #1 rstn = 1'b1;
        n_checks++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL t6_release: got req/valid=%b expected 00", {imem_req, instr_valid});
        end
        tick();
        n_checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h400, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL t6_restart: got req=%b addr=%h valid=%b expected 1 00000400 0", imem_req, imem_addr, instr_valid);
        end
    endtask

    initial begin
        $display("[TB] instr_fetch directed test start");
        test_reset();
        test_first_fetch();
        test_misaligned();
        test_bus_error();
        test_timeout_drain();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
